// File: rtl/nap_pkg.sv
// rtl/nap_pkg.sv - shared types, state encodings and BCD helpers for the nap timer
package nap_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t hour_ten;
    bcd_t hour_one;
    bcd_t min_ten;
    bcd_t min_one;
    bcd_t sec_ten;
    bcd_t sec_one;
  } nap_time_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_ALARM = 3'd4
  } nap_state_e;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_ALARM = 3'd4;

  function automatic logic bcd_valid(input nap_time_t t);
    return (t.hour_ten <= 4'd9) && (t.hour_one <= 4'd9) &&
           (t.min_ten  <= 4'd5) && (t.min_one  <= 4'd9) &&
           (t.sec_ten  <= 4'd5) && (t.sec_one  <= 4'd9);
  endfunction

endpackage

// File: rtl/nap_timer_ctrl_if.sv
// rtl/nap_timer_ctrl_if.sv - time/decrement bundle between the controller and the borrow chain
interface nap_timer_ctrl_if;
  import nap_pkg::*;

  nap_time_t time_cur;
  nap_time_t time_dec;
  logic      zero;

  modport master (output time_cur, input time_dec, input zero);
  modport slave  (input time_cur, output time_dec, output zero);

endinterface

// File: rtl/bcd_time_decrement.sv
// rtl/bcd_time_decrement.sv - combinational hh:mm:ss minus one second; zero flags a 00:00:00 result
module bcd_time_decrement
  import nap_pkg::*;
(
  nap_timer_ctrl_if.slave dec
);

  nap_time_t r;

  // Saturates at 00:00:00 so the countdown can never wrap to 99:59:59.
  always_comb begin
    r = dec.time_cur;
    if (dec.time_cur != '0) begin
      if (r.sec_one != 4'd0) r.sec_one = r.sec_one - 4'd1;
      else begin
        r.sec_one = 4'd9;
        if (r.sec_ten != 4'd0) r.sec_ten = r.sec_ten - 4'd1;
        else begin
          r.sec_ten = 4'd5;
          if (r.min_one != 4'd0) r.min_one = r.min_one - 4'd1;
          else begin
            r.min_one = 4'd9;
            if (r.min_ten != 4'd0) r.min_ten = r.min_ten - 4'd1;
            else begin
              r.min_ten = 4'd5;
              if (r.hour_one != 4'd0) r.hour_one = r.hour_one - 4'd1;
              else begin
                r.hour_one = 4'd9;
                r.hour_ten = r.hour_ten - 4'd1;
              end
            end
          end
        end
      end
    end
  end

  assign dec.time_dec = r;
  assign dec.zero     = (r == '0);

endmodule

// File: rtl/nap_timer_ctrl.sv
// rtl/nap_timer_ctrl.sv - nap countdown timer FSM; optional snooze via NAP_SNOOZE_EN
module nap_timer_ctrl
  import nap_pkg::*;
#(
  parameter int ALARM_TICKS = 60,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic [3:0] hour_ten_in,
  input  logic [3:0] hour_one_in,
  input  logic [3:0] min_ten_in,
  input  logic [3:0] min_one_in,
  input  logic [3:0] sec_ten_in,
  input  logic [3:0] sec_one_in,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
`ifdef NAP_SNOOZE_EN
  input  logic       snooze,
`endif
  output logic [3:0] hour_ten_out,
  output logic [3:0] hour_one_out,
  output logic [3:0] min_ten_out,
  output logic [3:0] min_one_out,
  output logic [3:0] sec_ten_out,
  output logic [3:0] sec_one_out,
  output logic       alarm,
  output logic       busy,
  output logic       load_err,
  output logic [2:0] state_out
);

  if (ALARM_TICKS < 1 || ALARM_TICKS > 255 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_param
    $error("nap_timer_ctrl: ALARM_TICKS or SNOOZE_MIN out of range");
  end

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  logic [2:0] state_q, state_d;
  nap_time_t  time_q, time_d;
  logic [7:0] acnt_q, acnt_d;
  logic       lerr_q, lerr_d;
  nap_time_t  load_time;

  nap_timer_ctrl_if u_dec_if ();
  bcd_time_decrement u_dec (.dec(u_dec_if.slave));

  assign u_dec_if.time_cur = time_q;
  assign load_time = '{hour_ten: hour_ten_in, hour_one: hour_one_in,
                       min_ten:  min_ten_in,  min_one:  min_one_in,
                       sec_ten:  sec_ten_in,  sec_one:  sec_one_in};

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    acnt_d  = acnt_q;
    lerr_d  = 1'b0;
    if (cancel) begin
      state_d = ST_IDLE;
      time_d  = '0;
      acnt_d  = '0;
    end else if (load && (state_q == ST_IDLE || state_q == ST_ARMED)) begin
      if (!bcd_valid(load_time)) begin
        lerr_d = 1'b1;
      end else if (load_time == '0) begin
        state_d = ST_IDLE;
        time_d  = '0;
      end else begin
        state_d = ST_ARMED;
        time_d  = load_time;
      end
    end else begin
      case (state_q)
        ST_ARMED, ST_PAUSE: if (start) state_d = ST_RUN;
        ST_RUN: begin
          // A pause landing on a tick wins; the tick is dropped.
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick_1hz) begin
            time_d = u_dec_if.time_dec;
            if (u_dec_if.zero) begin
              state_d = ST_ALARM;
              acnt_d  = '0;
            end
          end
        end
        ST_ALARM: begin
`ifdef NAP_SNOOZE_EN
          if (snooze) begin
            state_d = ST_RUN;
            time_d  = '{hour_ten: 4'd0, hour_one: 4'd0,
                        min_ten: 4'(SNOOZE_MIN / 10), min_one: 4'(SNOOZE_MIN % 10),
                        sec_ten: 4'd0, sec_one: 4'd0};
            acnt_d  = '0;
          end else
`endif
          if (tick_1hz) begin
            if (acnt_q == ALARM_LAST) begin
              state_d = ST_IDLE;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      acnt_q  <= '0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      acnt_q  <= acnt_d;
      lerr_q  <= lerr_d;
    end
  end

  assign hour_ten_out = time_q.hour_ten;
  assign hour_one_out = time_q.hour_one;
  assign min_ten_out  = time_q.min_ten;
  assign min_one_out  = time_q.min_one;
  assign sec_ten_out  = time_q.sec_ten;
  assign sec_one_out  = time_q.sec_one;
  assign alarm        = (state_q == ST_ALARM);
  assign busy         = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign load_err     = lerr_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// tb/tb_nap_timer_ctrl.sv - directed scoreboard bench for nap_timer_ctrl and its decrementer
module tb_nap_timer_ctrl;
  import nap_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0;
`ifdef NAP_SNOOZE_EN
  logic snooze = 1'b0;
`endif
  logic [3:0] ht_i = '0, ho_i = '0, mt_i = '0, mo_i = '0, st_i = '0, so_i = '0;
  logic [3:0] ht_o, ho_o, mt_o, mo_o, st_o, so_o;
  logic       alarm, busy, load_err;
  logic [2:0] state_out;

  int vectors = 0;
  int miscompares = 0;
  logic [29:0] exp_q[$];
  string       tag_q[$];
  logic [29:0] obs;

  always #5 clk = ~clk;

  nap_timer_ctrl #(.ALARM_TICKS(60), .SNOOZE_MIN(5)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick), .load(load),
    .hour_ten_in(ht_i), .hour_one_in(ho_i), .min_ten_in(mt_i),
    .min_one_in(mo_i), .sec_ten_in(st_i), .sec_one_in(so_i),
    .start(start), .pause(pause), .cancel(cancel),
`ifdef NAP_SNOOZE_EN
    .snooze(snooze),
`endif
    .hour_ten_out(ht_o), .hour_one_out(ho_o), .min_ten_out(mt_o),
    .min_one_out(mo_o), .sec_ten_out(st_o), .sec_one_out(so_o),
    .alarm(alarm), .busy(busy), .load_err(load_err), .state_out(state_out)
  );

  nap_timer_ctrl_if u_if ();
  bcd_time_decrement u_dec (.dec(u_if.slave));

  assign obs = {state_out, alarm, busy, load_err, ht_o, ho_o, mt_o, mo_o, st_o, so_o};

  function automatic logic [29:0] ex(input logic [2:0] s, input logic a, input logic b,
                                     input logic l, input logic [23:0] t);
    return {s, a, b, l, t};
  endfunction

  task automatic set_time(input logic [23:0] t);
    {ht_i, ho_i, mt_i, mo_i, st_i, so_i} = t;
  endtask

  task automatic clr();
    tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; cancel = 1'b0;
`ifdef NAP_SNOOZE_EN
    snooze = 1'b0;
`endif
  endtask

  task automatic check();
    logic [29:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic step(input string tag, input logic [29:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    clr();
    check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step("reset", ex(ST_IDLE, 0, 0, 0, 24'h000000));
    rst = 1'b0;
    tick = 1'b1;             step("idle_tick",  ex(ST_IDLE,  0, 0, 0, 24'h000000));

    set_time(24'h000003); load = 1'b1;
    step("load_3s",  ex(ST_ARMED, 0, 0, 0, 24'h000003));
    tick = 1'b1;  step("armed_tick", ex(ST_ARMED, 0, 0, 0, 24'h000003));
    start = 1'b1; step("start_3s",   ex(ST_RUN,   0, 1, 0, 24'h000003));
    tick = 1'b1;  step("tick_02",    ex(ST_RUN,   0, 1, 0, 24'h000002));
    tick = 1'b1;  step("tick_01",    ex(ST_RUN,   0, 1, 0, 24'h000001));
    tick = 1'b1;  step("tick_00",    ex(ST_ALARM, 1, 0, 0, 24'h000000));
    for (int i = 0; i < 58; i++) begin
      tick = 1'b1;
      adv();
    end
    tick = 1'b1;  step("alarm_59", ex(ST_ALARM, 1, 0, 0, 24'h000000));
    tick = 1'b1;  step("alarm_60", ex(ST_IDLE,  0, 0, 0, 24'h000000));

`ifdef NAP_SNOOZE_EN
    set_time(24'h000001); load = 1'b1;
    step("snz_load",  ex(ST_ARMED, 0, 0, 0, 24'h000001));
    start = 1'b1;  step("snz_start", ex(ST_RUN,   0, 1, 0, 24'h000001));
    tick = 1'b1;   step("snz_alarm", ex(ST_ALARM, 1, 0, 0, 24'h000000));
    snooze = 1'b1; step("snooze",    ex(ST_RUN,   0, 1, 0, 24'h000500));
    cancel = 1'b1; step("snz_cancel", ex(ST_IDLE, 0, 0, 0, 24'h000000));
`endif

    set_time(24'h010000); load = 1'b1;
    step("load_1h",  ex(ST_ARMED, 0, 0, 0, 24'h010000));
    start = 1'b1;  step("start_1h", ex(ST_RUN, 0, 1, 0, 24'h010000));
    tick = 1'b1;   step("borrow_1h", ex(ST_RUN, 0, 1, 0, 24'h005959));
    cancel = 1'b1; step("cancel_run", ex(ST_IDLE, 0, 0, 0, 24'h000000));

    set_time(24'h000010); load = 1'b1;
    step("load_10s", ex(ST_ARMED, 0, 0, 0, 24'h000010));
    start = 1'b1; step("start_10s", ex(ST_RUN, 0, 1, 0, 24'h000010));
    pause = 1'b1; tick = 1'b1;
    step("pause_tick", ex(ST_PAUSE, 0, 1, 0, 24'h000010));
    tick = 1'b1;  step("paused_tick", ex(ST_PAUSE, 0, 1, 0, 24'h000010));
    start = 1'b1; step("resume",      ex(ST_RUN,   0, 1, 0, 24'h000010));
    tick = 1'b1;  step("tick_09",     ex(ST_RUN,   0, 1, 0, 24'h000009));
    set_time(24'h000500); load = 1'b1;
    step("load_in_run", ex(ST_RUN, 0, 1, 0, 24'h000009));
    cancel = 1'b1; step("cancel_2", ex(ST_IDLE, 0, 0, 0, 24'h000000));

    set_time(24'h000060); load = 1'b1;
    step("bad_secten", ex(ST_IDLE, 0, 0, 1, 24'h000000));
    step("lerr_pulse",   ex(ST_IDLE, 0, 0, 0, 24'h000000));
    set_time(24'h000003); load = 1'b1;
    step("load_arm",     ex(ST_ARMED, 0, 0, 0, 24'h000003));
    set_time(24'h000A00); load = 1'b1;
    step("bad_minone",   ex(ST_ARMED, 0, 0, 1, 24'h000003));
    set_time(24'h006000); load = 1'b1;
    step("bad_minten",   ex(ST_ARMED, 0, 0, 1, 24'h000003));
    set_time(24'h000007); load = 1'b1; cancel = 1'b1;
    step("cancel_load",  ex(ST_IDLE, 0, 0, 0, 24'h000000));
    set_time(24'h000000); load = 1'b1;
    step("zero_load",    ex(ST_IDLE, 0, 0, 0, 24'h000000));

    set_time(24'h000020); load = 1'b1;
    step("load_20s",  ex(ST_ARMED, 0, 0, 0, 24'h000020));
    start = 1'b1; step("start_20s", ex(ST_RUN, 0, 1, 0, 24'h000020));
    tick = 1'b1;  step("tick_19",   ex(ST_RUN, 0, 1, 0, 24'h000019));
    rst = 1'b1;   step("rst_run",   ex(ST_IDLE, 0, 0, 0, 24'h000000));
    rst = 1'b0;

    u_if.time_cur = 24'h100000;
    #1;
    vectors++;
    assert (u_if.time_dec === 24'h095959 && u_if.zero === 1'b0) else begin
      miscompares++;
      $error("FAIL dec_10h observed=%h/%b expected=095959/0", u_if.time_dec, u_if.zero);
    end
    u_if.time_cur = 24'h000000;
    #1;
    vectors++;
    assert (u_if.time_dec === 24'h000000 && u_if.zero === 1'b1) else begin
      miscompares++;
      $error("FAIL dec_floor observed=%h/%b expected=000000/1", u_if.time_dec, u_if.zero);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nap_timer_ctrl.md
NAP_TIMER_CTRL -- requirements
Module: nap_timer_ctrl

Interface
REQ-001 SHALL have parameter ALARM_TICKS, default 60, meaning ticks the alarm sounds before auto-silence (range 1..255).
REQ-002 SHALL have parameter SNOOZE_MIN, default 5, meaning minutes reloaded on snooze (range 1..59).
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port tick_1hz  in  1  one-cycle pulse once per second.
REQ-006 SHALL have port load  in  1  one-cycle pulse; the setting block has completed (completeSetting).
REQ-007 SHALL have ports hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in  in  4 each  BCD duration to load.
REQ-008 SHALL have ports start, pause, cancel  in  1 each  one-cycle user command pulses.
REQ-009 SHALL have port snooze  in  1  one-cycle pulse; present only with NAP_SNOOZE_EN.
REQ-010 SHALL have ports hour_ten_out..sec_one_out  out  4 each  registered BCD remaining time.
REQ-011 SHALL have port alarm  out  1  level, high while in ALARM.
REQ-012 SHALL have port busy  out  1  high in RUN or PAUSE.
REQ-013 SHALL have port load_err  out  1  one-cycle pulse on a rejected load.
REQ-014 SHALL have port state_out  out  3  current state encoding.

Function
REQ-015 States SHALL be IDLE, ARMED, RUN, PAUSE, ALARM.
REQ-016 load in IDLE/ARMED with valid nonzero BCD SHALL capture the digits and go to ARMED; an all-zero duration SHALL stay in IDLE.
REQ-017 Valid BCD: every digit <=9, min_ten and sec_ten <=5; otherwise SHALL pulse load_err next cycle and keep state and time unchanged.
REQ-018 load in RUN/PAUSE/ALARM SHALL be ignored with no load_err.
REQ-019 start in ARMED or PAUSE SHALL go to RUN; pause in RUN SHALL go to PAUSE; cancel in any state SHALL clear the time to zero and go to IDLE.
REQ-020 Per-cycle priority SHALL be cancel > load > start/pause/snooze > tick_1hz.
REQ-021 In RUN, each tick_1hz SHALL decrement by one second with BCD borrow (sec_one 0->9, sec_ten 0->5, min_one 0->9, min_ten 0->5, hour_one 0->9, hour_ten 0..9); outputs SHALL update the cycle after the tick.
REQ-022 A tick decrementing 00:00:01 to 00:00:00 SHALL enter ALARM in the same edge; alarm SHALL be high from the next cycle.
REQ-023 Ticks SHALL be ignored outside RUN and ALARM; a pause coinciding with a tick SHALL pause without decrementing.
REQ-024 ALARM SHALL count ALARM_TICKS ticks, then go to IDLE with alarm low; cancel SHALL silence immediately.
REQ-025 Time SHALL never wrap below 00:00:00.

Reset
REQ-026 On rst all time outputs SHALL be 0, state IDLE, alarm/busy/load_err 0, alarm tick counter 0; rst mid-countdown SHALL discard the countdown.

Configuration
REQ-027 With NAP_SNOOZE_EN defined, snooze in ALARM SHALL load 00:SNOOZE_MIN:00 and go to RUN; snooze elsewhere SHALL be ignored.
REQ-028 Without NAP_SNOOZE_EN the snooze port and logic SHALL be absent; ALARM exits only by timeout or cancel.

Structure
REQ-029 Package nap_pkg SHALL hold the state enum, the 4-bit BCD digit type, a 6-digit time struct, and the state_out encodings.
REQ-030 The BCD borrow chain SHALL be a sub-module bcd_time_decrement (combinational: time in -> time minus 1 s, zero flag).

Verification
REQ-031 Load 00:00:03, start, 3 ticks -> outputs 02, 01, 00; alarm high the cycle after the third tick.
REQ-032 Load 01:00:00, start, 1 tick -> 00:59:59, busy=1.
REQ-033 Load with sec_ten=6 -> load_err single pulse, state unchanged.
REQ-034 RUN at 00:00:10, pause together with a tick -> PAUSE, time stays 00:00:10; start + 1 tick -> 00:00:09.
REQ-035 ALARM, 60 ticks -> IDLE, alarm low; with NAP_SNOOZE_EN, snooze in ALARM -> RUN at 00:05:00.
REQ-036 cancel and load in the same cycle while ARMED -> IDLE, time 00:00:00; rst during RUN -> all outputs 0 next cycle.
